// File: rtl/adsb_ppm_encoder_if.sv
// rtl/adsb_ppm_encoder_if.sv - frame request and amplitude sample stream bundle for the PPM encoder
interface adsb_ppm_encoder_if #(
  parameter int NUM_BITS = 112
);
  logic                start;
  logic [NUM_BITS-1:0] data_in;
  logic [7:0]          data_out;
  logic                valid_out;
  logic                busy;
  logic                done;

  modport master (
    output start, data_in,
    input  data_out, valid_out, busy, done
  );

  modport slave (
    input  start, data_in,
    output data_out, valid_out, busy, done
  );
endinterface

// File: rtl/adsb_ppm_encoder.sv
// rtl/adsb_ppm_encoder.sv - Mode-S/ADS-B preamble + PPM sample stream generator
module adsb_ppm_encoder #(
  parameter int         SAMPLES_PER_US = 80,
  parameter int         NUM_BITS       = 112,
  parameter logic [7:0] HIGH_LEVEL     = 8'd200,
  parameter logic [7:0] LOW_LEVEL      = 8'd0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  adsb_ppm_encoder_if.slave bus
);

  localparam logic [6:0] US_LAST   = 7'(SAMPLES_PER_US - 1);
  localparam logic [6:0] US_HALF   = 7'(SAMPLES_PER_US / 2);
  localparam logic [6:0] PRE_LAST  = 7'd7;
  localparam logic [6:0] DATA_LAST = 7'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [6:0]          r_us;
  logic [6:0]          w_us_nxt;
  logic [6:0]          r_sym;
  logic [6:0]          w_sym_nxt;
  logic [NUM_BITS-1:0] r_msg;
  logic [NUM_BITS-1:0] w_msg_nxt;
  logic                w_us_wrap;
  logic                w_high_nxt;

  logic [7:0]          r_data_out;
  logic                r_valid_out;
  logic                r_busy;
  logic                r_done;

  assign w_us_wrap = (r_us == US_LAST);

  // Pulse/no-pulse decision for a given (state, symbol, sample-in-symbol, current bit)
  function automatic logic f_high(input state_t st, input logic [6:0] sym,
                                  input logic [6:0] us, input logic cur_bit);
    logic first_half;
    first_half = (us < US_HALF);
    case (st)
      S_PRE:   f_high = ((sym == 7'd0 || sym == 7'd1) && first_half) ||
                        ((sym == 7'd3 || sym == 7'd4) && !first_half);
      S_DATA:  f_high = cur_bit ? first_half : !first_half;
      default: f_high = 1'b0;
    endcase
    return f_high;
  endfunction

  // State, counters and message shift register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_us    <= '0;
      r_sym   <= '0;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_us    <= w_us_nxt;
      r_sym   <= w_sym_nxt;
      r_msg   <= w_msg_nxt;
    end
  end

  // Next-state logic: sym clears on every state change, msg shifts as each data bit ends
  always_comb begin
    w_state_nxt = r_state;
    w_us_nxt    = r_us;
    w_sym_nxt   = r_sym;
    w_msg_nxt   = r_msg;
    case (r_state)
      S_IDLE: begin
        w_us_nxt  = '0;
        w_sym_nxt = '0;
        if (bus.start) begin
          w_state_nxt = S_PRE;
          w_msg_nxt   = bus.data_in;
        end
      end
      S_PRE: begin
        if (w_us_wrap) begin
          w_us_nxt = '0;
          if (r_sym == PRE_LAST) begin
            w_state_nxt = S_DATA;
            w_sym_nxt   = '0;
          end else begin
            w_sym_nxt = r_sym + 7'd1;
          end
        end else begin
          w_us_nxt = r_us + 7'd1;
        end
      end
      S_DATA: begin
        if (w_us_wrap) begin
          w_us_nxt  = '0;
          w_msg_nxt = {r_msg[NUM_BITS-2:0], 1'b0};
          if (r_sym == DATA_LAST) begin
            w_state_nxt = S_DONE;
            w_sym_nxt   = '0;
          end else begin
            w_sym_nxt = r_sym + 7'd1;
          end
        end else begin
          w_us_nxt = r_us + 7'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_us_nxt    = '0;
        w_sym_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_us_nxt    = '0;
        w_sym_nxt   = '0;
      end
    endcase
  end

  assign w_high_nxt = f_high(w_state_nxt, w_sym_nxt, w_us_nxt, w_msg_nxt[NUM_BITS-1]);

  // Outputs registered from next-state values so sample k lands exactly k+1 cycles after start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out  <= LOW_LEVEL;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_data_out  <= w_high_nxt ? HIGH_LEVEL : LOW_LEVEL;
      r_valid_out <= (w_state_nxt == S_PRE) || (w_state_nxt == S_DATA);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_adsb_ppm_encoder.sv
// tb/tb_adsb_ppm_encoder.sv - self-checking bench for the ADS-B PPM encoder
module tb_adsb_ppm_encoder;
  localparam int SPU = 80;
  localparam int NB  = 112;
  localparam int NS  = 8 * SPU + NB * SPU;
  localparam logic [NB-1:0] REAL_MSG = 112'h8D4840D6202CC371C32CE0576098;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adsb_ppm_encoder_if #(.NUM_BITS(NB)) bus ();

  adsb_ppm_encoder #(
    .SAMPLES_PER_US(SPU),
    .NUM_BITS      (NB),
    .HIGH_LEVEL    (8'd200),
    .LOW_LEVEL     (8'd0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int         sel;
    int         idx;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cap[NS];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input int sel, input int idx, input int exp);
    vec_t v;
    v.sel = sel;
    v.idx = idx;
    v.exp = 8'(exp);
    vecs.push_back(v);
  endfunction

  function automatic logic [NB-1:0] rand_msg();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[NB-1:0];
  endfunction

  // Reference: sample k of a frame straight from the pulse-position rules
  function automatic logic [7:0] ref_sample(input logic [NB-1:0] m, input int k);
    int s;
    int u;
    bit hi;
    if (k < 8 * SPU) begin
      s  = k / SPU;
      u  = k % SPU;
      hi = ((s == 0 || s == 1) && u < SPU / 2) || ((s == 3 || s == 4) && u >= SPU / 2);
    end else begin
      s  = (k - 8 * SPU) / SPU;
      u  = (k - 8 * SPU) % SPU;
      hi = m[NB-1-s] ? (u < SPU / 2) : (u >= SPU / 2);
    end
    return hi ? 8'd200 : 8'd0;
  endfunction

  task automatic send_frame(input logic [NB-1:0] m, input string tag,
                            input int pulse_a, input int pulse_b, input int flip_at,
                            input int rst_at, input int done_mode, input logic [NB-1:0] m_next);
    int bad;
    int first_bad;
    int cbad;
    bad = 0;
    first_bad = -1;
    cbad = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = m;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      cap[k] = bus.data_out;
      if (bus.data_out !== ref_sample(m, k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (bus.valid_out !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) cbad++;
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk({tag, " samples before reset"}, bad, 0);
        chk({tag, " data_out at reset"}, bus.data_out, 0);
        chk({tag, " valid_out at reset"}, bus.valid_out, 0);
        chk({tag, " busy at reset"}, bus.busy, 0);
        @(negedge clk);
        chk({tag, " valid_out after reset"}, bus.valid_out, 0);
        chk({tag, " done after reset"}, bus.done, 0);
        return;
      end
      bus.start = (k == pulse_a) || (k == pulse_b);
      if (k == flip_at) bus.data_in = ~bus.data_in;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, " sample mismatches"}, bad, 0);
    if (bad != 0) chk({tag, " first bad sample index"}, first_bad, -1);
    chk({tag, " valid/busy/done mismatches during frame"}, cbad, 0);
    chk({tag, " done in DONE cycle"}, bus.done, 1);
    chk({tag, " busy in DONE cycle"}, bus.busy, 1);
    chk({tag, " valid_out in DONE cycle"}, bus.valid_out, 0);
    chk({tag, " data_out in DONE cycle"}, bus.data_out, 0);
    if (done_mode == 1) bus.start = 1'b1;
    if (done_mode == 2) begin
      bus.start   = 1'b1;
      bus.data_in = m_next;
    end
    @(negedge clk);
    chk({tag, " busy after DONE"}, bus.busy, 0);
    chk({tag, " done after DONE"}, bus.done, 0);
    chk({tag, " valid_out after DONE"}, bus.valid_out, 0);
    if (done_mode == 2) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " next frame valid at T+9603"}, bus.valid_out, 1);
      chk({tag, " next frame busy at T+9603"}, bus.busy, 1);
      chk({tag, " next frame sample 0"}, bus.data_out, ref_sample(m_next, 0));
    end else begin
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, " no extra frame valid"}, bus.valid_out, 0);
      chk({tag, " no extra frame busy"}, bus.busy, 0);
    end
  endtask

  initial begin
    logic [NB-1:0] r1;
    logic [NB-1:0] r2;
    logic [NB-1:0] dec;
    int            h1;
    int            h2;

    add_vec(0, 0, 200);    add_vec(0, 39, 200);   add_vec(0, 40, 0);     add_vec(0, 79, 0);
    add_vec(0, 80, 200);   add_vec(0, 119, 200);  add_vec(0, 120, 0);    add_vec(0, 279, 0);
    add_vec(0, 280, 200);  add_vec(0, 319, 200);  add_vec(0, 320, 0);    add_vec(0, 359, 0);
    add_vec(0, 360, 200);  add_vec(0, 399, 200);  add_vec(0, 400, 0);    add_vec(0, 639, 0);
    add_vec(0, 640, 0);    add_vec(0, 679, 0);    add_vec(0, 680, 200);  add_vec(0, 719, 200);
    add_vec(0, 9599, 200);
    add_vec(1, 0, 200);    add_vec(1, 639, 0);    add_vec(1, 640, 200);  add_vec(1, 679, 200);
    add_vec(1, 680, 0);    add_vec(1, 719, 0);    add_vec(1, 720, 200);  add_vec(1, 9559, 200);
    add_vec(1, 9560, 0);   add_vec(1, 9599, 0);

    bus.start   = 1'b0;
    bus.data_in = '0;
    rst         = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.start   = 1'b1;
      bus.data_in = rand_msg();
    end
    chk("reset data_out", bus.data_out, 0);
    chk("reset valid_out", bus.valid_out, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    chk("no frame from start in reset", bus.valid_out, 0);
    chk("idle busy after reset", bus.busy, 0);

    send_frame('0, "zeros", -1, -1, -1, -1, 0, '0);
    foreach (vecs[i]) if (vecs[i].sel == 0) chk($sformatf("zeros sample %0d", vecs[i].idx), cap[vecs[i].idx], vecs[i].exp);

    send_frame('1, "ones", -1, -1, -1, -1, 0, '0);
    foreach (vecs[i]) if (vecs[i].sel == 1) chk($sformatf("ones sample %0d", vecs[i].idx), cap[vecs[i].idx], vecs[i].exp);

    send_frame(REAL_MSG, "real+restarts", 10, 5000, -1, -1, 1, '0);
    dec = '0;
    for (int i = 0; i < NB; i++) begin
      h1 = 0;
      h2 = 0;
      for (int u = 0; u < SPU; u++) begin
        if (cap[8 * SPU + i * SPU + u] > 8'd100) begin
          if (u < SPU / 2) h1++;
          else h2++;
        end
      end
      dec[NB-1-i] = (h1 > h2);
    end
    chk("loopback decode bits mismatching", $countones(dec ^ REAL_MSG), 0);

    r1 = rand_msg();
    send_frame(r1, "data_in flip", -1, -1, 700, -1, 0, '0);

    r1 = rand_msg();
    r2 = rand_msg();
    send_frame(r1, "back-to-back", -1, -1, -1, -1, 2, r2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after abandon", bus.busy, 0);

    r1 = rand_msg();
    send_frame(r1, "mid reset", -1, -1, -1, 5000, 0, '0);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    chk("start during reset valid", bus.valid_out, 0);
    chk("start during reset busy", bus.busy, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    chk("after reset valid", bus.valid_out, 0);
    chk("after reset done", bus.done, 0);

    r1 = rand_msg();
    send_frame(r1, "post reset frame", -1, -1, -1, -1, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adsb_ppm_encoder.md
# adsb_ppm_encoder

Transmit-side counterpart of the pulse-position decoder. It takes a 112-bit Mode-S/ADS-B message and produces an 8-bit amplitude sample stream at 80 samples per microsecond: an 8 µs preamble followed by 112 PPM-encoded bit periods of 1 µs each. The stream drives the DAC or test-pattern path, and is timed so the decoder core can consume it directly in loopback.

## Interface
- `SAMPLES_PER_US`, default 80: samples per 1 µs symbol. Must be even; the half-symbol is `SAMPLES_PER_US/2`.
- `NUM_BITS`, default 112: payload bits per frame.
- `HIGH_LEVEL`, default 8'd200: sample value while a pulse is on.
- `LOW_LEVEL`, default 8'd0: sample value while a pulse is off, and while idle.
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: frame request. Sampled only in IDLE.
- `data_in`, input, NUM_BITS: message to send, MSB transmitted first. Latched on the accepted `start`.
- `data_out`, output, 8: registered amplitude sample.
- `valid_out`, output, 1: high for every frame sample, preamble and data.
- `busy`, output, 1: high from the first frame sample through the DONE cycle.
- `done`, output, 1: one-cycle pulse after the last sample.

## Operation
- **FSM states.**
  - IDLE: waits for `start`.
  - PRE: symbols 0..7.
  - DATA: symbols 0..NUM_BITS-1.
  - DONE: lasts one cycle, then returns to IDLE.
- **Transitions.**
  - IDLE→PRE on `start`=1.
  - PRE→DATA when `sym`=7 and `us`=SAMPLES_PER_US-1.
  - DATA→DONE when `sym`=NUM_BITS-1 and `us`=SAMPLES_PER_US-1.
  - DONE→IDLE unconditionally.
- **Counters.**
  - `us`: 7-bit, 0..SAMPLES_PER_US-1, wraps to 0.
  - `sym`: 7-bit. Increments when `us` wraps and clears to 0 on every state change.
  - Both counters are 0 in IDLE.
- **Latch.** On the accepted `start`, `data_in` is copied into the NUM_BITS-bit shift register `msg`. Any change to `data_in` after that has no effect on the current frame.
- **Preamble rule.** A sample is HIGH_LEVEL when either condition holds, otherwise LOW_LEVEL:
  - `sym`∈{0,1} and `us`<SAMPLES_PER_US/2;
  - `sym`∈{3,4} and `us`≥SAMPLES_PER_US/2.
  - This places pulses at 0, 1.0, 3.5 and 4.5 µs.
- **Data rule.** The current bit is `msg[NUM_BITS-1]`.
  - Bit 1: HIGH_LEVEL for `us`<SAMPLES_PER_US/2, then LOW_LEVEL.
  - Bit 0: LOW_LEVEL for `us`<SAMPLES_PER_US/2, then HIGH_LEVEL.
  - `msg` shifts left by one when `us` wraps in DATA.
- **Idle outputs.** In IDLE and DONE: `data_out`=LOW_LEVEL, `valid_out`=0.
- **`start` outside IDLE.** Ignored in PRE, DATA and DONE. It is not queued.
- **Reset values.** `rst`=1 at any time, including mid-frame, forces immediately:
  - state=IDLE, `us`=0, `sym`=0, `msg`=0;
  - `data_out`=LOW_LEVEL, `valid_out`=0, `busy`=0, `done`=0.
  - An interrupted frame is abandoned, not resumed.

## Timing
- `start` accepted at the rising edge ending cycle T (state IDLE) → sample k, k=0..9599, appears on `data_out` during cycle T+1+k, with `valid_out`=1 for exactly those 9600 cycles.
- Preamble occupies samples 0..639. Payload bit i (i=0 is the MSB) occupies samples 640+80·i .. 719+80·i.
- `done`=1 and `busy`=1 during cycle T+9601 only. From T+9602 the block is in IDLE with `busy`=0.
  - A `start` held high from T+9602 gives first sample T+9603, so the minimum frame-to-frame gap is 2 idle cycles.
- **Registered outputs.** All outputs are driven from flops, with no combinational path from `start` or `data_in` to any output. Sample value, `valid_out` and `busy` are computed from next-state values so they align with the sample index.
- `start` asserted in the same cycle as a `rst` release is ignored. Reset dominates through the edge at which `rst` is sampled high.

## Test plan
- **Reset.** `rst` pulse with random inputs → `data_out`=0, `valid_out`=0, `busy`=0, `done`=0; `start` during reset produces no frame.
- **Preamble.** `start` with `data_in`=0 → samples are 200 at 0–39, 80–119, 280–319 and 360–399, and 0 at all other indices in 0–639.
- **Payload extremes.**
  - `data_in`=all ones → for each i, samples 640+80i..679+80i are 200 and 680+80i..719+80i are 0.
  - `data_in`=all zeros → the mirror image.
  - In both cases `valid_out` is high for exactly 9600 cycles and `done` pulses once at T+9601.
- **Real frame.** `data_in`=112'h8D4840D6202CC371C32CE0576098 → stream matches the reference model sample-for-sample. In loopback into the decoder, the recovered message equals the input.
- **Handshake.**
  - `start` re-pulsed at samples 10, 5000 and in the DONE cycle → ignored, exactly one frame produced.
  - `data_in` changed to ~`data_in` at sample 700 → transmitted bits unchanged.
  - Back-to-back `start` held high → second frame's first sample at T+9603.
- **Mid-frame reset.** `rst` at sample 5000 → next cycle `data_out`=0 and `valid_out`=0, with no `done`. After release, a new `start` produces a full, correct 9600-sample frame.
